// File: rtl/muldiv_ctrl_pkg.sv
// Shared execute-stage constants: ALU control codes, multiply/divide codes
// and the multiply/divide sequencer state type.
package muldiv_ctrl_pkg;

    // Existing ALU control codes
    localparam logic [4:0] EXE_AND   = 5'd0;
    localparam logic [4:0] EXE_OR    = 5'd1;
    localparam logic [4:0] EXE_XOR   = 5'd2;
    localparam logic [4:0] EXE_NOR   = 5'd3;
    localparam logic [4:0] EXE_ADD   = 5'd4;
    localparam logic [4:0] EXE_ADDU  = 5'd5;
    localparam logic [4:0] EXE_SUB   = 5'd6;
    localparam logic [4:0] EXE_SUBU  = 5'd7;
    localparam logic [4:0] EXE_SLT   = 5'd8;
    localparam logic [4:0] EXE_SLTU  = 5'd9;
    localparam logic [4:0] EXE_SLL   = 5'd10;
    localparam logic [4:0] EXE_SRL   = 5'd11;
    localparam logic [4:0] EXE_SRA   = 5'd12;
    localparam logic [4:0] EXE_LUI   = 5'd13;

    // Multiply/divide and HI/LO move codes
    localparam logic [4:0] EXE_MULT  = 5'd14;
    localparam logic [4:0] EXE_MULTU = 5'd15;
    localparam logic [4:0] EXE_DIV   = 5'd16;
    localparam logic [4:0] EXE_DIVU  = 5'd17;
    localparam logic [4:0] EXE_MTHI  = 5'd18;
    localparam logic [4:0] EXE_MTLO  = 5'd19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } muldiv_state_t;

    // Signed ops take operand magnitudes and need a sign fix-up.
    function automatic logic is_signed_op(input logic [4:0] code);
        return (code == EXE_MULT) || (code == EXE_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One shift-add (multiply) or restoring-divide step per enabled cycle
// on a 2*DATA_W shift register {upper, lower}.
module muldiv_iter
    import muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic              div_mode,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    output logic [DATA_W-1:0] upper,
    output logic [DATA_W-1:0] lower
);

    logic [DATA_W-1:0] upper_q, lower_q, opb_q;
    logic [DATA_W-1:0] upper_d, lower_d;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W:0]   sub_diff;

    // Next value of the shift register for one iteration
    always_comb begin
        upper_d  = upper_q;
        lower_d  = lower_q;
        add_sum  = {1'b0, upper_q}
                 + (lower_q[0] ? {1'b0, opb_q} : '0);
        sub_diff = {upper_q, lower_q[DATA_W-1]} - {1'b0, opb_q};
        if (div_mode) begin
            if (!sub_diff[DATA_W]) begin
                upper_d = sub_diff[DATA_W-1:0];
                lower_d = {lower_q[DATA_W-2:0], 1'b1};
            end else begin
                upper_d = {upper_q[DATA_W-2:0], lower_q[DATA_W-1]};
                lower_d = {lower_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            upper_d = add_sum[DATA_W:1];
            lower_d = {add_sum[0], lower_q[DATA_W-1:1]};
        end
    end

    // Load operands on launch, step while enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upper_q <= '0;
            lower_q <= '0;
            opb_q   <= '0;
        end else if (load) begin
            upper_q <= '0;
            lower_q <= opa;
            opb_q   <= opb;
        end else if (en) begin
            upper_q <= upper_d;
            lower_q <= lower_d;
        end
    end

    assign upper = upper_q;
    assign lower = lower_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: FSM, iteration counter, sign fix-up and
// the architectural HI/LO registers.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        op,
    input  logic [DATA_W-1:0] srca,
    input  logic [DATA_W-1:0] srcb,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    muldiv_state_t state_q, state_d;

    logic [CNT_W-1:0]    cnt_q;
    logic                is_div_q;
    logic                qneg_q;
    logic                rneg_q;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic                done_q;

    logic                load;
    logic                iter_en;
    logic                fix_we;
    logic                mthi_we;
    logic                mtlo_we;
    logic                last;
    logic                sgn;
    logic                div_launch;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W-1:0]   it_upper, it_lower;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   rem_fix, quo_fix;

    // Operand magnitudes and corrected results
    always_comb begin
        sgn        = is_signed_op(op);
        div_launch = (op == EXE_DIV) || (op == EXE_DIVU);
        mag_a      = (sgn && srca[DATA_W-1]) ? -srca : srca;
        mag_b      = (sgn && srcb[DATA_W-1]) ? -srcb : srcb;
        last       = (cnt_q == CNT_W'(DATA_W - 1));
        prod_fix   = qneg_q ? -{it_upper, it_lower}
                            : {it_upper, it_lower};
        rem_fix    = rneg_q ? -it_upper : it_upper;
        quo_fix    = qneg_q ? -it_lower : it_lower;
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        iter_en = 1'b0;
        fix_we  = 1'b0;
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    case (op)
                        EXE_MULT, EXE_MULTU: begin
                            state_d = MUL;
                            load    = 1'b1;
                        end
                        EXE_DIV, EXE_DIVU: begin
                            state_d = DIV;
                            load    = 1'b1;
                        end
                        EXE_MTHI: mthi_we = 1'b1;
                        EXE_MTLO: mtlo_we = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    iter_en = 1'b1;
                    if (last) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                fix_we  = !flush;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Iteration counter and result-sign flags latched at launch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else if (load) begin
            cnt_q    <= '0;
            is_div_q <= div_launch;
            qneg_q   <= sgn & (srca[DATA_W-1] ^ srcb[DATA_W-1]);
            rneg_q   <= sgn & srca[DATA_W-1];
        end else if (iter_en) begin
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // HI/LO writeback and the done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fix_we;
            if (fix_we) begin
                if (is_div_q) begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end else begin
                    hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                    lo_q <= prod_fix[DATA_W-1:0];
                end
            end else begin
                if (mthi_we) hi_q <= srca;
                if (mtlo_we) lo_q <= srca;
            end
        end
    end

    muldiv_iter #(
        .DATA_W (DATA_W)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .en       (iter_en),
        .div_mode (is_div_q),
        .opa      (mag_a),
        .opb      (mag_b),
        .upper    (it_upper),
        .lower    (it_lower)
    );

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized scoreboard bench for muldiv_ctrl with a plain-arithmetic
// reference model and directed control cases.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  op = 5'd0;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic prev_done = 1'b0;

    muldiv_ctrl #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {hi, lo} from the architectural definition
    function automatic logic [63:0] ref_result(input logic [4:0] code,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb_, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (code)
            EXE_MULT:  begin p = 64'(sa * sb_); return p; end
            EXE_MULTU: begin p = {32'd0, a} * {32'd0, b}; return p; end
            EXE_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, a[31] ? 32'd1 : 32'hFFFF_FFFF};
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        if (done) begin
            if (prev_done) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_twice: got 1 expected 0");
            end
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done expected none");
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("result_hi", {32'd0, hi}, {32'd0, e[63:32]});
                check("result_lo", {32'd0, lo}, {32'd0, e[31:0]});
            end
        end
        prev_done = done;
    end

    // Launch one op; optional start poke while busy and optional flush
    task automatic run_op(input logic [4:0] code, input logic [31:0] a,
                          input logic [31:0] b, input int poke,
                          input int flush_at);
        logic [63:0] e;
        int n;
        @(negedge clk);
        op = code;
        srca = a;
        srcb = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (code == EXE_MTHI || code == EXE_MTLO) begin
            if (code == EXE_MTHI) model_hi = a;
            else model_lo = a;
            check("mt_busy", {63'd0, busy}, 64'd0);
            check("mt_hi", {32'd0, hi}, {32'd0, model_hi});
            check("mt_lo", {32'd0, lo}, {32'd0, model_lo});
            return;
        end
        if (flush_at < 0) begin
            e = ref_result(code, a, b);
            sb.push_back(e);
            model_hi = e[63:32];
            model_lo = e[31:0];
        end
        n = 0;
        while (busy && n < 40) begin
            if (n == poke) begin
                start = 1'b1;
                op = EXE_DIVU;
                srca = ~a;
                srcb = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (n == flush_at) begin
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
                check("flush_busy", {63'd0, busy}, 64'd0);
                check("flush_hi", {32'd0, hi}, {32'd0, model_hi});
                check("flush_lo", {32'd0, lo}, {32'd0, model_lo});
                return;
            end
            n++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("busy_cycles", 64'(n), 64'd33);
        check("done_pulse", {63'd0, done}, 64'd1);
    endtask

    // Async reset in the middle of an operation
    task automatic reset_mid_op(input int at);
        int n;
        @(negedge clk);
        op = EXE_MULTU;
        srca = 32'hDEAD_BEEF;
        srcb = 32'h1234_5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (busy && n < at) begin
            n++;
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_hi = '0;
        model_lo = '0;
    endtask

    // Flush in the same cycle as start: nothing launches
    task automatic flush_with_start(input logic [4:0] code);
        @(negedge clk);
        op = code;
        srca = 32'hCAFE_F00D;
        srcb = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("fs_busy", {63'd0, busy}, 64'd0);
        check("fs_hi", {32'd0, hi}, {32'd0, model_hi});
        check("fs_lo", {32'd0, lo}, {32'd0, model_lo});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ops[4];
        ops[0] = EXE_MULT;
        ops[1] = EXE_MULTU;
        ops[2] = EXE_DIV;
        ops[3] = EXE_DIVU;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(EXE_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_op(EXE_MULT, -32'd3, 32'd7, -1, -1);
        run_op(EXE_DIV, -32'd7, 32'd2, -1, -1);
        run_op(EXE_DIVU, 32'd7, 32'd0, -1, -1);
        run_op(EXE_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_op(EXE_DIV, -32'd9, 32'd0, -1, -1);
        run_op(EXE_MTHI, 32'h1234, 32'd0, -1, -1);
        run_op(EXE_MTLO, 32'h5678, 32'd0, -1, -1);
        run_op(EXE_MULT, 32'd100, -32'd100, 5, -1);
        run_op(EXE_DIVU, 32'd1000, 32'd7, 31, -1);
        run_op(EXE_MULTU, 32'hABCD_0123, 32'h0F0F_0F0F, -1, 10);
        run_op(EXE_DIV, 32'h7FFF_FFFF, 32'd3, -1, 32);
        flush_with_start(EXE_MTHI);
        flush_with_start(EXE_MULT);
        reset_mid_op(20);

        for (int i = 0; i < 40; i++) begin
            run_op(ops[$urandom_range(0, 3)], pick_operand(),
                   pick_operand(), -1, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
